even_seq_checker: RTL and testbench

Receive-side checker for the even-number generator's 4-bit output stream. Samples the incoming value on qualified cycles, locks onto the 0, 2, 4, …, 14, 0 sequence, and flags every odd or out-of-sequence value. Reports lock, fault, wrap and a saturating error count so the generator can be monitored in-system or on a bench.

---
 rtl/even_seq_checker.sv | 126 ++++++++++++
 tb/tb_even_seq_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/even_seq_checker.sv
// even_seq_checker: receive-side checker for a step-by-2 (mod 2^WIDTH) sample stream.
// It hunts for an even sample, locks on, and then tracks the expected next value.
// Outputs are registered with one-cycle latency: lock/fault status, error and wrap
// pulses, a saturating error count, and the expected value.
// Optional feature macro EVEN_CHK_RESYNC_EN. When it is defined, a LOCK mismatch
// re-aligns instead of faulting.
module even_seq_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP    = WIDTH'(2);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q;
  logic             locked_q;
  logic             fault_q;
  logic             err_pulse_q;
  logic             wrap_pulse_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] din_plus2_d;
  logic [WIDTH-1:0] exp_plus2_d;

  // Saturating error increment and the two "+2" candidates for the next expected value
  always_comb begin
    err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + ERR_W'(1);
    din_plus2_d = din + STEP;
    exp_plus2_d = expected_q + STEP;
  end

  // Checker FSM; status outputs are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
      expected_q   <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (clr) begin
        // Clear wins over a same-cycle sample, which is discarded
        state_q     <= HUNT;
        locked_q    <= 1'b0;
        fault_q     <= 1'b0;
        err_count_q <= '0;
        expected_q  <= '0;
      end else if (din_valid) begin
        case (state_q)
          HUNT: begin
            if (!din[0]) begin
              state_q    <= LOCK;
              locked_q   <= 1'b1;
              expected_q <= din_plus2_d;
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
            end
          end
          LOCK: begin
            if (din == expected_q) begin
              expected_q   <= exp_plus2_d;
              wrap_pulse_q <= (din == '0);
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
`ifdef EVEN_CHK_RESYNC_EN
              if (!din[0]) begin
                // Even but off-sequence: re-align on this sample and stay locked
                expected_q <= din_plus2_d;
              end else begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
              end
`else
              // Any mismatch is fatal; expected holds for post-mortem inspection
              state_q  <= FAULT;
              locked_q <= 1'b0;
              fault_q  <= 1'b1;
`endif
            end
          end
          FAULT: begin
            // Samples are ignored; only clr or rst leaves this state
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_even_seq_checker.sv
// Directed bench for even_seq_checker. It covers lock-up, hunt errors, LOCK mismatch
// (fault or resync depending on EVEN_CHK_RESYNC_EN), counter saturation, clr priority
// and asynchronous reset.
module tb_even_seq_checker;

  localparam int WIDTH = 4;
  localparam int ERR_W = 8;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             locked;
  logic             fault;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  int n_checks;
  int n_fail;

  even_seq_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .locked     (locked),
    .fault      (fault),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .expected   (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic l, input logic f, input logic e,
                      input logic w, input int cnt, input int ex);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(e));
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(w));
    chk({tag, ".err_count"}, 32'(err_count), 32'(cnt));
    chk({tag, ".expected"}, 32'(expected), 32'(ex));
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge
  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] smp;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream 0,2,..,14,0,2: lock on the first sample, one wrap on the second 0
    for (int i = 0; i < 10; i++) begin
      smp = WIDTH'(2 * i);
      cyc(1'b1, smp, 1'b0);
      outs($sformatf("stream[%0d]", i), 1, 0, 0, (i == 8), 0, int'(WIDTH'(smp + 2)));
    end
    cyc(1'b0, 4'd9, 1'b0);
    outs("idle_hold", 1, 0, 0, 0, 0, 4);

    // Hunt with odd samples first: 3,5 are errors, 6 locks, 8 matches
    cyc(1'b0, 4'd0, 1'b1);
    outs("clr1", 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 4'd3, 1'b0);
    outs("hunt3", 0, 0, 1, 0, 1, 0);
    cyc(1'b1, 4'd5, 1'b0);
    outs("hunt5", 0, 0, 1, 0, 2, 0);
    cyc(1'b1, 4'd6, 1'b0);
    outs("hunt6", 1, 0, 0, 0, 2, 8);
    cyc(1'b1, 4'd8, 1'b0);
    outs("hunt8", 1, 0, 0, 0, 2, 10);

    // LOCK mismatch: expected 6, inject 10
    cyc(1'b0, 4'd0, 1'b1);
    outs("clr2", 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 4'd4, 1'b0);
    outs("lock4", 1, 0, 0, 0, 0, 6);
    cyc(1'b1, 4'd10, 1'b0);
`ifdef EVEN_CHK_RESYNC_EN
    outs("mis10", 1, 0, 1, 0, 1, 12);
    cyc(1'b1, 4'd12, 1'b0);
    outs("resync12", 1, 0, 0, 0, 1, 14);
    cyc(1'b1, 4'd5, 1'b0);
    outs("odd_to_hunt", 0, 0, 1, 0, 2, 14);
`else
    outs("mis10", 0, 1, 1, 0, 1, 6);
    cyc(1'b1, 4'd6, 1'b0);
    outs("fault_ign6", 0, 1, 0, 0, 1, 6);
    cyc(1'b1, 4'd7, 1'b0);
    outs("fault_ign7", 0, 1, 0, 0, 1, 6);
    cyc(1'b0, 4'd0, 1'b0);
    outs("fault_idle", 0, 1, 0, 0, 1, 6);
`endif
    cyc(1'b0, 4'd0, 1'b1);
    outs("clr3", 0, 0, 0, 0, 0, 0);

    // 300 back-to-back odd samples: count saturates at 255, pulse stays high
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 4'd1, 1'b0);
      chk($sformatf("sat_pulse[%0d]", i), 32'(err_pulse), 32'd1);
      chk($sformatf("sat_cnt[%0d]", i), 32'(err_count), (i < 255) ? 32'(i + 1) : 32'd255);
    end
    cyc(1'b0, 4'd1, 1'b0);
    outs("sat_idle", 0, 0, 0, 0, 255, 0);

    // clr together with a valid odd sample while locked: no error, back to HUNT
    cyc(1'b1, 4'd2, 1'b0);
    outs("pre_clr_lock", 1, 0, 0, 0, 255, 4);
    cyc(1'b1, 4'd7, 1'b1);
    outs("clr_vs_valid", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-stream while locked
    cyc(1'b1, 4'd0, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    outs("pre_rst_lock", 1, 0, 0, 0, 0, 4);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'd8, 1'b0);
    outs("relock8", 1, 0, 0, 0, 0, 10);
    cyc(1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
